// File: rtl/test_pattern_gen.sv
// Purpose: selectable video test patterns (ramps, bars, checker, scrolling grey) driven from sync counters.
// Latency: one cycle from hcnt/vcnt sample to registered r/g/b; pattern state changes only on the frame tick.
// Backpressure: none; free-running pixel pipeline. Optional auto-cycle via TPG_AUTOCYCLE_EN.
module test_pattern_gen #(
    parameter int             CW          = 3,
    parameter int             HACT        = 256,
    parameter int             VACT        = 192,
    parameter logic [CW-1:0]  BORDER      = CW'(4),
    parameter int             AUTO_FRAMES = 50
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    hcnt,
    input  logic [8:0]    vcnt,
    input  logic [1:0]    mode_sel,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic [1:0]    mode
);

    localparam int         L      = $clog2(HACT);
    localparam logic [8:0] HACT_9 = 9'(HACT);
    localparam logic [8:0] VACT_9 = 9'(VACT);
    localparam logic [8:0] V1_9   = 9'(VACT / 3);
    localparam logic [8:0] V2_9   = 9'((2 * VACT) / 3);

    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] g_q, g_d;
    logic [CW-1:0] b_q, b_d;
    logic [1:0]    mode_q, mode_d;
    logic [L-1:0]  scroll_q, scroll_d;
    logic          match_q, match_d;

    logic          active;
    logic          match;
    logic          tick;
    logic [CW-1:0] lvl_h;
    logic [CW-1:0] lvl_x;
    logic [2:0]    bar_v;

`ifdef TPG_AUTOCYCLE_EN
    localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          unused_mode_sel;
    assign unused_mode_sel = ^mode_sel;
`endif

    // Frame tick detection and pattern-state update (mode, scroll, frame counter).
    always_comb begin
        match    = (hcnt == 9'd0) && (vcnt == VACT_9);
        tick     = match && !match_q;
        match_d  = match;
        mode_d   = mode_q;
        scroll_d = scroll_q;
`ifdef TPG_AUTOCYCLE_EN
        frame_cnt_d = frame_cnt_q;
`endif
        if (tick) begin
            // HACT is a power of two, so natural L-bit wrap gives HACT-1 -> 0.
            scroll_d = scroll_q + 1'b1;
`ifdef TPG_AUTOCYCLE_EN
            if (frame_cnt_q == FW'(AUTO_FRAMES - 1)) begin
                frame_cnt_d = '0;
                mode_d      = mode_q + 2'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
`else
            mode_d = mode_sel;
`endif
        end
    end

    // Colour generation from the current (pre-tick) pattern state.
    always_comb begin
        active = (hcnt < HACT_9) && (vcnt < VACT_9);
        lvl_h  = hcnt[L-1 -: CW];
        // Sum is L bits wide so the carry out of the scroll add is dropped.
        lvl_x  = CW'((hcnt[L-1:0] + scroll_q) >> (L - CW));
        bar_v  = ~hcnt[L-1 -: 3];
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        if (!active) begin
            r_d = BORDER;
            g_d = BORDER;
            b_d = BORDER;
        end else begin
            case (mode_q)
                2'd0: begin
                    if (vcnt < V1_9) begin
                        r_d = lvl_h;
                    end else if (vcnt < V2_9) begin
                        g_d = lvl_h;
                    end else begin
                        b_d = lvl_h;
                    end
                end
                2'd1: begin
                    g_d = {CW{bar_v[2]}};
                    r_d = {CW{bar_v[1]}};
                    b_d = {CW{bar_v[0]}};
                end
                2'd2: begin
                    r_d = {CW{hcnt[4] ^ vcnt[4]}};
                    g_d = {CW{hcnt[4] ^ vcnt[4]}};
                    b_d = {CW{hcnt[4] ^ vcnt[4]}};
                end
                default: begin
                    r_d = lvl_x;
                    g_d = lvl_x;
                    b_d = lvl_x;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            scroll_q <= '0;
            match_q  <= 1'b0;
`ifdef TPG_AUTOCYCLE_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            scroll_q <= scroll_d;
            match_q  <= match_d;
`ifdef TPG_AUTOCYCLE_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign r    = r_q;
    assign g    = g_q;
    assign b    = b_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Purpose: vector-table bench for test_pattern_gen with a one-deep-latency scoreboard.
// Latency: each vector's expectation is checked one clock edge after it is driven.
// Backpressure: none; inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_test_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] hcnt = '0;
    logic [8:0] vcnt = '0;
    logic [1:0] mode_sel = '0;
    logic [2:0] r, g, b;
    logic [1:0] mode;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst_n;
        logic [8:0] h;
        logic [8:0] v;
        logic [1:0] sel;
        logic [2:0] er;
        logic [2:0] eg;
        logic [2:0] eb;
        logic [1:0] em;
    } vec_t;

    typedef struct {
        logic [2:0] er;
        logic [2:0] eg;
        logic [2:0] eb;
        logic [1:0] em;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    test_pattern_gen #(
        .CW(3), .HACT(256), .VACT(192), .BORDER(3'd4), .AUTO_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt), .mode_sel(mode_sel),
        .r(r), .g(g), .b(b), .mode(mode)
    );

    function automatic void add(input logic rs, input int h, input int v, input int sel,
                                input int er, input int eg, input int eb, input int em);
        vec_t t;
        t.rst_n = rs;
        t.h     = 9'(h);
        t.v     = 9'(v);
        t.sel   = 2'(sel);
        t.er    = 3'(er);
        t.eg    = 3'(eg);
        t.eb    = 3'(eb);
        t.em    = 2'(em);
        vecs.push_back(t);
    endfunction

    task automatic drive(input vec_t t, input int id);
        exp_t e;
        @(negedge clk);
        rst_n    = t.rst_n;
        hcnt     = t.h;
        vcnt     = t.v;
        mode_sel = t.sel;
        e.er = t.er; e.eg = t.eg; e.eb = t.eb; e.em = t.em; e.id = id;
        sb.push_back(e);
    endtask

    // Monitor: each rising edge retires the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if (r !== mon_e.er || g !== mon_e.eg || b !== mon_e.eb || mode !== mon_e.em) begin
                bad++;
                $display("FAIL vec%0d: got r=%0d g=%0d b=%0d mode=%0d, want r=%0d g=%0d b=%0d mode=%0d",
                         mon_e.id, r, g, b, mode, mon_e.er, mon_e.eg, mon_e.eb, mon_e.em);
            end
        end
    end

    initial begin
`ifdef TPG_AUTOCYCLE_EN
        logic [1:0] seq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        repeat (2) add(0, 100, 10, 2, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            add(1, 0, 192, 2, 4, 4, 4, seq[k]);
            add(1, 1, 192, 2, 4, 4, 4, seq[k]);
        end
        add(0, 100, 10, 2, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 192, 2, 4, 4, 4, seq[k]);
            add(1, 1, 192, 2, 4, 4, 4, seq[k]);
        end
        add(1, 40, 10, 2, 7, 7, 0, 1);
        add(0, 40, 10, 2, 0, 0, 0, 0);
        // Counter must restart at 0: first tick keeps mode 0, second advances.
        add(1, 0, 192, 2, 4, 4, 4, 0);
        add(1, 1, 192, 2, 4, 4, 4, 0);
        add(1, 0, 192, 2, 4, 4, 4, 1);
        add(1, 40, 10, 2, 7, 7, 0, 1);
`else
        // Reset held, then release with ramp output from the sampled counters.
        repeat (4) add(0, 100, 10, 0, 0, 0, 0, 0);
        add(1, 100, 10, 0, 3, 0, 0, 0);
        // Mode 0 ramps and band/active boundaries.
        add(1, 160, 70, 0, 0, 5, 0, 0);
        add(1, 300, 70, 0, 4, 4, 4, 0);
        add(1, 224, 63, 0, 7, 0, 0, 0);
        add(1, 224, 64, 0, 0, 7, 0, 0);
        add(1, 224, 128, 0, 0, 0, 7, 0);
        add(1, 255, 191, 0, 0, 0, 7, 0);
        add(1, 256, 0, 0, 4, 4, 4, 0);
        add(1, 5, 192, 0, 4, 4, 4, 0);
        // mode_sel change mid-frame has no effect until the tick.
        add(1, 100, 50, 1, 3, 0, 0, 0);
        add(1, 160, 70, 1, 0, 5, 0, 0);
        add(1, 0, 192, 1, 4, 4, 4, 1);
        // Colour bars.
        add(1, 40, 10, 1, 7, 7, 0, 1);
        add(1, 250, 10, 1, 0, 0, 0, 1);
        add(1, 0, 10, 1, 7, 7, 7, 1);
        add(1, 160, 10, 1, 7, 0, 0, 1);
        // Checkerboard.
        add(1, 0, 192, 2, 4, 4, 4, 2);
        add(1, 16, 0, 2, 7, 7, 7, 2);
        add(1, 16, 16, 2, 0, 0, 0, 2);
        add(1, 40, 20, 2, 7, 7, 7, 2);
        // Mid-frame reset clears mode and scroll.
        add(0, 40, 20, 2, 0, 0, 0, 0);
        // Three ticks in mode 3 -> scroll 3.
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 192, 3, 4, 4, 4, 3);
            add(1, 1, 192, 3, 4, 4, 4, 3);
        end
        add(1, 253, 0, 3, 0, 0, 0, 3);
        add(1, 29, 0, 3, 1, 1, 1, 3);
        add(1, 29, 1, 0, 1, 1, 1, 3);
        // Counters held on the tick point: exactly one tick, scroll 3 -> 4.
        repeat (5) add(1, 0, 192, 3, 4, 4, 4, 3);
        add(1, 251, 0, 3, 7, 7, 7, 3);
        add(1, 28, 0, 3, 1, 1, 1, 3);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i], i);
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d outstanding, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
